// File: rtl/tic_tac_toe_pkg.sv
// Shared encodings for the tic-tac-toe referee.
//   cell_t    : contents of one board cell
//   result_t  : game outcome reported on the who output
//   turn_t    : whose move is expected next (ANY before the first move)
//   state_t   : referee state
//   WIN_LINES : cell index triples of the 3 rows, 3 columns and 2 diagonals
package tic_tac_toe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        X     = 2'b01,
        O     = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        XWIN = 2'b01,
        OWIN = 2'b10,
        DRAW = 2'b11
    } result_t;

    typedef enum logic [1:0] {
        ANY = 2'b00,
        TX  = 2'b01,
        TO  = 2'b10
    } turn_t;

    typedef enum logic {
        PLAYING   = 1'b0,
        GAME_OVER = 1'b1
    } state_t;

    localparam int unsigned WIN_LINES [8][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

endpackage

// File: rtl/tic_tac_toe_result.sv
// Combinational judge of a 3x3 board.
//   board  : 9 cells, row-major, index 0 = top-left
//   result : XWIN/OWIN if any line holds three equal marks, DRAW if the board
//            is full without a line, NONE otherwise. A win outranks a draw.
module tic_tac_toe_result
    import tic_tac_toe_pkg::*;
(
    input  cell_t   board [9],
    output result_t result
);

    logic [7:0] line_x;
    logic [7:0] line_o;
    logic [8:0] filled;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_line
            assign line_x[gi] = (board[WIN_LINES[gi][0]] == X) &&
                                (board[WIN_LINES[gi][1]] == X) &&
                                (board[WIN_LINES[gi][2]] == X);
            assign line_o[gi] = (board[WIN_LINES[gi][0]] == O) &&
                                (board[WIN_LINES[gi][1]] == O) &&
                                (board[WIN_LINES[gi][2]] == O);
        end
        for (gi = 0; gi < 9; gi++) begin : g_fill
            assign filled[gi] = (board[gi] != EMPTY);
        end
    endgenerate

    always_comb begin
        result = NONE;
        if (|line_x) begin
            result = XWIN;
        end else if (|line_o) begin
            result = OWIN;
        end else if (&filled) begin
            result = DRAW;
        end
    end

endmodule

// File: rtl/tic_tac_toe_game.sv
// Two-player tic-tac-toe referee core.
//   clk, rst                       : clock, synchronous active-high reset
//   playX / playO                  : move request levels; a move fires on 0->1
//   playerX_position / playerO_... : target cell 0..8, row-major
//   pos1..pos9                     : cell contents (00 empty, 01 X, 10 O)
//   who                            : 00 playing, 01 X won, 10 O won, 11 draw
// The board is registered; the outcome is judged from the registered board
// and registered again, so who follows the deciding move by one clock.
module tic_tac_toe_game
    import tic_tac_toe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       playX,
    input  logic       playO,
    input  logic [3:0] playerX_position,
    input  logic [3:0] playerO_position,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic [1:0] who
);

    cell_t   board_q [9];
    cell_t   board_d [9];
    logic    playx_q;
    logic    playo_q;
    turn_t   turn_q, turn_d;
    state_t  state_q, state_d;
    result_t who_q, who_d;
    result_t result;

    logic       req_x, req_o;
    logic [3:0] mv_pos;
    cell_t      mv_cell;
    turn_t      mv_turn, mv_other;
    logic       mv_ok;
    logic       accept;
    logic [8:0] cell_sel;
    logic [8:0] cell_free;

    tic_tac_toe_result u_result (
        .board  (board_q),
        .result (result)
    );

    always_comb begin
        req_x    = playX & ~playx_q;
        req_o    = playO & ~playo_q;
        mv_pos   = req_x ? playerX_position : playerO_position;
        mv_cell  = req_x ? X  : O;
        mv_turn  = req_x ? TX : TO;
        mv_other = req_x ? TO : TX;
        // Simultaneous requests cancel each other out.
        mv_ok    = (state_q == PLAYING) && (req_x ^ req_o) &&
                   (mv_pos <= 4'd8) &&
                   ((turn_q == ANY) || (turn_q == mv_turn));
    end

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_cell
            assign cell_sel[gi]  = (mv_pos == 4'(gi));
            assign cell_free[gi] = (board_q[gi] == EMPTY);
            assign board_d[gi]   = (accept && cell_sel[gi]) ? mv_cell : board_q[gi];
        end
    endgenerate

    always_comb begin
        accept  = mv_ok && |(cell_sel & cell_free);
        turn_d  = accept ? mv_other : turn_q;
        // Once decided the outcome is frozen until reset.
        who_d   = (state_q == GAME_OVER) ? who_q : result;
        state_d = (who_d != NONE) ? GAME_OVER : state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                board_q[i] <= EMPTY;
            end
            // Treat buttons as already pressed so one held through reset is not a move.
            playx_q <= 1'b1;
            playo_q <= 1'b1;
            turn_q  <= ANY;
            state_q <= PLAYING;
            who_q   <= NONE;
        end else begin
            for (int i = 0; i < 9; i++) begin
                board_q[i] <= board_d[i];
            end
            playx_q <= playX;
            playo_q <= playO;
            turn_q  <= turn_d;
            state_q <= state_d;
            who_q   <= who_d;
        end
    end

    assign pos1 = board_q[0];
    assign pos2 = board_q[1];
    assign pos3 = board_q[2];
    assign pos4 = board_q[3];
    assign pos5 = board_q[4];
    assign pos6 = board_q[5];
    assign pos7 = board_q[6];
    assign pos8 = board_q[7];
    assign pos9 = board_q[8];
    assign who  = who_q;

endmodule

// File: tb/tb_tic_tac_toe_game.sv
// Randomised and directed bench for tic_tac_toe_game. A driver issues moves
// and resets, updates a rule-level model of the game, and queues the board
// and outcome it expects; a monitor pops and compares after the DUT settles.
module tb_tic_tac_toe_game;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       playX = 1'b0;
    logic       playO = 1'b0;
    logic [3:0] playerX_position = 4'd0;
    logic [3:0] playerO_position = 4'd0;
    logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
    logic [1:0] who;

    always #5 clk = ~clk;

    tic_tac_toe_game dut (
        .clk              (clk),
        .rst              (rst),
        .playX            (playX),
        .playO            (playO),
        .playerX_position (playerX_position),
        .playerO_position (playerO_position),
        .pos1 (pos1), .pos2 (pos2), .pos3 (pos3),
        .pos4 (pos4), .pos5 (pos5), .pos6 (pos6),
        .pos7 (pos7), .pos8 (pos8), .pos9 (pos9),
        .who  (who)
    );

    typedef struct {
        logic [17:0] brd;
        logic [1:0]  res;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: plain game rules.
    int m_board [9];   // 0 empty, 1 X, 2 O
    int m_turn;        // -1 anyone, 0 X, 1 O
    int m_over;
    int m_lines [8][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    function automatic int model_result();
        int full = 1;
        for (int l = 0; l < 8; l++) begin
            int a = m_board[m_lines[l][0]];
            if (a != 0 && a == m_board[m_lines[l][1]] && a == m_board[m_lines[l][2]])
                return a;
        end
        for (int i = 0; i < 9; i++) if (m_board[i] == 0) full = 0;
        return full ? 3 : 0;
    endfunction

    task automatic push_exp(input string tag);
        exp_t e;
        e.brd = '0;
        for (int i = 0; i < 9; i++) e.brd[17 - 2 * i -: 2] = 2'(m_board[i]);
        e.res = 2'(model_result());
        e.tag = tag;
        sb_q.push_back(e);
        repeat (2) @(negedge clk);
    endtask

    // pl: 0 = X, 1 = O, 2 = both buttons at once.
    task automatic do_move(input int pl, input int pos, input string tag);
        @(negedge clk);
        if (pl != 1) playerX_position = 4'(pos);
        if (pl != 0) playerO_position = 4'(pos);
        if (pl != 1) playX = 1'b1;
        if (pl != 0) playO = 1'b1;
        repeat (3) @(negedge clk);
        playX = 1'b0;
        playO = 1'b0;
        repeat (2) @(negedge clk);
        if (m_over == 0 && pl != 2 && pos <= 8 && m_board[pos] == 0 &&
            (m_turn == -1 || m_turn == pl)) begin
            m_board[pos] = pl + 1;
            m_turn       = 1 - pl;
            if (model_result() != 0) m_over = 1;
        end
        push_exp(tag);
    endtask

    // Optionally hold playX high across the reset to show it is not a move.
    task automatic do_reset(input int cycles, input int hold_x, input string tag);
        @(negedge clk);
        if (hold_x != 0) playX = 1'b1;
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        playX = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 9; i++) m_board[i] = 0;
        m_turn = -1;
        m_over = 0;
        push_exp(tag);
    endtask

    // Monitor: sample one cycle-offset away from the active edge.
    initial begin
        exp_t        e;
        logic [17:0] act;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9};
                $display("txn %-12s board=%05h who=%0d (exp board=%05h who=%0d)",
                         e.tag, act, who, e.brd, e.res);
                checks++;
                if (act !== e.brd) begin
                    failures++;
                    $display("FAIL %s board: actual=%05h required=%05h", e.tag, act, e.brd);
                end
                checks++;
                if (who !== e.res) begin
                    failures++;
                    $display("FAIL %s who: actual=%0d required=%0d", e.tag, who, e.res);
                end
            end
        end
    end

    initial begin
        int pl, pos, waited;

        // 1. long reset with X held through release
        do_reset(10, 1, "reset");

        // 2. O wins on the top row, then a late X move is ignored
        do_move(1, 0, "o0");
        do_move(0, 4, "x4");
        do_move(1, 1, "o1");
        do_move(0, 8, "x8");
        do_move(1, 2, "o2_win");
        do_move(0, 6, "x6_over");

        // 3. same-cell and turn violations
        do_reset(2, 0, "rst3a");
        do_move(0, 4, "x4");
        do_move(1, 4, "o4_taken");
        do_reset(2, 0, "rst3b");
        do_move(0, 0, "x0");
        do_move(0, 1, "x1_turn");
        do_move(1, 1, "o1_after");

        // 4. out-of-range positions and simultaneous presses
        do_reset(2, 0, "rst4");
        do_move(0, 9, "x9");
        do_move(0, 15, "x15");
        do_move(2, 3, "both3");
        do_move(1, 12, "o12");
        do_move(0, 3, "x3");

        // 5a. full board, no line
        do_reset(2, 0, "rst5a");
        do_move(0, 0, "x0");
        do_move(1, 1, "o1");
        do_move(0, 2, "x2");
        do_move(1, 4, "o4");
        do_move(0, 3, "x3");
        do_move(1, 5, "o5");
        do_move(0, 7, "x7");
        do_move(1, 6, "o6");
        do_move(0, 8, "x8_draw");

        // 5b. X wins on the anti-diagonal
        do_reset(2, 0, "rst5b");
        do_move(0, 2, "x2");
        do_move(1, 0, "o0");
        do_move(0, 4, "x4");
        do_move(1, 1, "o1");
        do_move(0, 6, "x6_win");

        // 6. reset from game over and from mid-game; either side may start
        do_reset(1, 0, "rst_over");
        do_move(1, 8, "o8_start");
        do_move(0, 0, "x0");
        do_reset(1, 0, "rst_mid");
        do_move(0, 5, "x5_start");

        // randomised games
        for (int g = 0; g < 25; g++) begin
            do_reset(1 + $urandom_range(0, 2), $urandom_range(0, 1), "rst_rand");
            for (int m = 0; m < 12; m++) begin
                pl  = ($urandom_range(0, 9) == 0) ? 2 : $urandom_range(0, 1);
                pos = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 8) : $urandom_range(9, 15);
                do_move(pl, pos, "rand");
            end
        end

        waited = 0;
        while (sb_q.size() > 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: actual=%0d pending required=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
